h264invtransform_core: RTL and testbench

- Inverse 4x4 integer core transform for the reconstruction path of the H.264 encoder.
- It consumes the dequantised coefficient rows that the forward core transform side produces, and emits residual rows for the reconstruction adder.
- Operation: horizontal 1-D inverse transform on each input row, 4x4 transpose buffer, vertical 1-D inverse transform, then rounding (x+32)>>>6 with saturation.
- An internal FSM sequences load, vertical compute and drain, with valid/ready handshakes on both sides.

---
 rtl/h264invtransform_core_if.sv | 24 ++
 rtl/h264invtransform_core.sv | 136 +++++++++++++
 tb/tb_h264invtransform_core.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/h264invtransform_core_if.sv
// Row stream bundle for the 4x4 inverse transform: coefficient rows in, residual rows out.
// A row transfers on a rising CLK edge where VALID, READY and the core ENABLE are all high; VALID and data hold until then.
interface h264invtransform_core_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [4*IN_W-1:0]  IN_ROW;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               OUT_LAST;
  logic [4*OUT_W-1:0] OUT_ROW;

  modport master (
    output IN_VALID, IN_ROW, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_ROW, OUT_LAST
  );

  modport slave (
    input  IN_VALID, IN_ROW, OUT_READY,
    output IN_READY, OUT_VALID, OUT_ROW, OUT_LAST
  );
endinterface

// File: rtl/h264invtransform_core.sv
// H.264 4x4 inverse core transform: row kernel on load, column kernel one column per
// cycle, (x+32)>>>6 rounding with saturation, then rows drained in order.
module h264invtransform_core #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  h264invtransform_core_if.slave     bus,
  output logic                       BUSY,
  output logic [1:0]                 STATE_DBG
);
  localparam int HW = IN_W + 2;
  localparam int VW = IN_W + 4;
  localparam logic signed [VW-1:0] RND    = VW'(32);
  localparam logic signed [VW-1:0] SAT_HI = VW'((1 << (OUT_W-1)) - 1);
  localparam logic signed [VW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {LOAD = 2'd0, VERT = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_nxt;
  logic [1:0] rcnt, ccnt, ocnt;
  logic in_fire, out_fire;

  logic signed [HW-1:0] hbuf [4][4];  // [row][col]
  logic [OUT_W-1:0]     obuf [4][4];  // [row][col]
  logic signed [HW-1:0] hx   [4];
  logic signed [VW-1:0] vx   [4];
  logic [4*HW-1:0]      hk;
  logic [4*VW-1:0]      vk;
  logic [OUT_W-1:0]     vcol [4];

  function automatic logic [4*HW-1:0] hkern(input logic signed [HW-1:0] a, b, c, d);
    logic signed [HW-1:0] e, f, g, h;
    e = a + c;
    f = a - c;
    g = (b >>> 1) - d;
    h = b + (d >>> 1);
    return {e - h, f - g, f + g, e + h};
  endfunction

  function automatic logic [4*VW-1:0] vkern(input logic signed [VW-1:0] a, b, c, d);
    logic signed [VW-1:0] e, f, g, h;
    e = a + c;
    f = a - c;
    g = (b >>> 1) - d;
    h = b + (d >>> 1);
    return {e - h, f - g, f + g, e + h};
  endfunction

  function automatic logic [OUT_W-1:0] rnd_sat(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] r;
    r = (v + RND) >>> 6;
    if (r > SAT_HI)      return SAT_HI[OUT_W-1:0];
    else if (r < SAT_LO) return SAT_LO[OUT_W-1:0];
    else                 return r[OUT_W-1:0];
  endfunction

  assign in_fire   = ENABLE && bus.IN_VALID && (state == LOAD);
  assign out_fire  = ENABLE && bus.OUT_READY && (state == DRAIN);
  assign BUSY      = !((state == LOAD) && (rcnt == 2'd0));
  assign STATE_DBG = state;

  // Row kernel on the incoming row; inputs are sign-extended so no sum can wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hx[i] = {{2{bus.IN_ROW[i*IN_W+IN_W-1]}}, bus.IN_ROW[i*IN_W +: IN_W]};
    end
    hk = hkern(hx[0], hx[1], hx[2], hx[3]);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vx[i] = {{2{hbuf[i][ccnt][HW-1]}}, hbuf[i][ccnt]};
    end
    vk = vkern(vx[0], vx[1], vx[2], vx[3]);
    for (int i = 0; i < 4; i++) begin
      vcol[i] = rnd_sat(vk[i*VW +: VW]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= LOAD;
    else if (ENABLE) state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.IN_READY  = 1'b0;
    bus.OUT_VALID = 1'b0;
    bus.OUT_LAST  = 1'b0;
    bus.OUT_ROW   = '0;
    case (state)
      LOAD: begin
        bus.IN_READY = 1'b1;
        if (in_fire && (rcnt == 2'd3)) state_nxt = VERT;
      end
      VERT: begin
        if (ccnt == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.OUT_VALID = 1'b1;
        bus.OUT_LAST  = (ocnt == 2'd3);
        bus.OUT_ROW   = {obuf[ocnt][3], obuf[ocnt][2], obuf[ocnt][1], obuf[ocnt][0]};
        if (out_fire && (ocnt == 2'd3)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Counters wrap 3->0 on the phase's last step, so they are already clear at the next phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rcnt <= 2'd0;
      ccnt <= 2'd0;
      ocnt <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          hbuf[i][j] <= '0;
          obuf[i][j] <= '0;
        end
      end
    end else if (ENABLE) begin
      if (in_fire) begin
        for (int j = 0; j < 4; j++) hbuf[rcnt][j] <= hk[j*HW +: HW];
        rcnt <= rcnt + 2'd1;
      end
      if (state == VERT) begin
        for (int i = 0; i < 4; i++) obuf[i][ccnt] <= vcol[i];
        ccnt <= ccnt + 2'd1;
      end
      if (out_fire) ocnt <= ocnt + 2'd1;
    end
  end
endmodule

// File: tb/tb_h264invtransform_core.sv
// Directed bench for h264invtransform_core: hand-computed residual blocks, latency,
// backpressure, gaps, ENABLE freeze and mid-block reset.
module tb_h264invtransform_core;
  localparam int IN_W  = 16;
  localparam int OUT_W = 10;
  localparam int RW    = 4*IN_W;
  localparam int OW    = 4*OUT_W;

  // clock / reset
  logic       CLK = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic       BUSY;
  logic [1:0] STATE_DBG;
  int         cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  h264invtransform_core_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  h264invtransform_core #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .bus       (bus),
    .BUSY      (BUSY),
    .STATE_DBG (STATE_DBG)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] irow(input int a, input int b, input int c, input int d);
    return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endfunction

  function automatic logic [OW-1:0] orow(input int a, input int b, input int c, input int d);
    return {OUT_W'(d), OUT_W'(c), OUT_W'(b), OUT_W'(a)};
  endfunction

  task automatic push4(input logic [OW-1:0] e0, e1, e2, e3);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // acc returns the edge count right after the accepting edge
  task automatic send_row(input logic [RW-1:0] row, output int acc);
    logic ok;
    ok = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.IN_ROW   = row;
    for (int k = 0; k < 40 && !ok; k++) begin
      ok = bus.IN_READY && ENABLE;
      tick();
    end
    acc = cyc;
    bus.IN_VALID = 1'b0;
    check("in_accept", OW'(ok), OW'(1));
  endtask

  task automatic send_block(input logic [RW-1:0] r0, r1, r2, r3, input int gap, output int acc);
    send_row(r0, acc);
    repeat (gap) tick();
    send_row(r1, acc);
    repeat (gap) tick();
    send_row(r2, acc);
    repeat (gap) tick();
    send_row(r3, acc);
  endtask

  // A cycle is numbered by the edge that ends it, so a first-valid cycle is (edge count + 1).
  task automatic collect_block(input string tag, input int acc, input int exp_lat,
                               input int stall_row, input int stall_n);
    logic          seen;
    logic [OW-1:0] held;
    logic [OW-1:0] e;
    seen = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.OUT_VALID) seen = 1'b1;
      else tick();
    end
    check({tag, "_valid_seen"}, OW'(seen), OW'(1));
    check({tag, "_latency"}, OW'(cyc + 1 - acc), OW'(exp_lat));
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        bus.OUT_READY = 1'b0;
        held = bus.OUT_ROW;
        repeat (stall_n) begin
          tick();
          check({tag, "_stall_row"}, bus.OUT_ROW, held);
          check({tag, "_stall_valid"}, OW'(bus.OUT_VALID), OW'(1));
        end
        bus.OUT_READY = 1'b1;
      end
      e = exp_q.pop_front();
      check({tag, "_row"}, bus.OUT_ROW, e);
      check({tag, "_last"}, OW'(bus.OUT_LAST), OW'(r == 3));
      check({tag, "_valid"}, OW'(bus.OUT_VALID), OW'(1));
      tick();
    end
    check({tag, "_done_valid"}, OW'(bus.OUT_VALID), OW'(0));
    check({tag, "_done_ready"}, OW'(bus.IN_READY), OW'(1));
    check({tag, "_done_busy"}, OW'(BUSY), OW'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, OW'(bus.IN_READY), OW'(1));
    check({tag, "_out_valid"}, OW'(bus.OUT_VALID), OW'(0));
    check({tag, "_out_last"}, OW'(bus.OUT_LAST), OW'(0));
    check({tag, "_out_row"}, bus.OUT_ROW, OW'(0));
    check({tag, "_busy"}, OW'(BUSY), OW'(0));
    check({tag, "_state"}, OW'(STATE_DBG), OW'(0));
  endtask

  int acc;
  logic [OW-1:0] ones, mones;

  initial begin
    RESET = 1'b1;
    ENABLE = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_ROW = '0;
    bus.OUT_READY = 1'b0;
    ones  = orow(1, 1, 1, 1);
    mones = orow(-1, -1, -1, -1);
    repeat (3) tick();
    check_idle("reset");
    RESET = 1'b0;
    tick();

    // DC block
    push4(ones, ones, ones, ones);
    send_block(irow(64, 0, 0, 0), '0, '0, '0, 0, acc);
    check("dc_state_vert", OW'(STATE_DBG), OW'(1));
    check("dc_busy", OW'(BUSY), OW'(1));
    check("dc_in_ready_low", OW'(bus.IN_READY), OW'(0));
    collect_block("dc", acc, 5, -1, 0);

    // negative DC: (-64+32)>>>6 = -1
    push4(mones, mones, mones, mones);
    send_block(irow(-64, 0, 0, 0), '0, '0, '0, 0, acc);
    collect_block("neg_dc", acc, 5, -1, 0);

    // single AC coefficient: horizontal row0 = [64,32,-32,-64]
    push4(orow(1, 1, 0, -1), orow(1, 1, 0, -1), orow(1, 1, 0, -1), orow(1, 1, 0, -1));
    send_block(irow(0, 64, 0, 0), '0, '0, '0, 0, acc);
    collect_block("ac", acc, 5, -1, 0);

    // saturation high and low
    push4(orow(511, 511, 511, 511), orow(511, 511, 511, 511),
          orow(511, 511, 511, 511), orow(511, 511, 511, 511));
    send_block(irow(32767, 0, 0, 0), '0, '0, '0, 0, acc);
    collect_block("sat_hi", acc, 5, -1, 0);
    push4(orow(-512, -512, -512, -512), orow(-512, -512, -512, -512),
          orow(-512, -512, -512, -512), orow(-512, -512, -512, -512));
    send_block(irow(-32768, 0, 0, 0), '0, '0, '0, 0, acc);
    collect_block("sat_lo", acc, 5, -1, 0);

    // DC in row 1 only exercises the transpose: columns see b=64 -> [64,32,-32,-64]
    push4(ones, ones, orow(0, 0, 0, 0), mones);
    send_block('0, irow(64, 0, 0, 0), '0, '0, 2, acc);
    bus.IN_VALID = 1'b1;
    bus.IN_ROW = irow(999, -999, 555, 123);
    tick();
    check("ignored_in_ready", OW'(bus.IN_READY), OW'(0));
    tick();
    bus.IN_VALID = 1'b0;
    collect_block("gap", acc, 5, -1, 0);

    // output backpressure on row 1
    push4(orow(1, 1, 0, -1), orow(1, 1, 0, -1), orow(1, 1, 0, -1), orow(1, 1, 0, -1));
    send_block(irow(0, 64, 0, 0), '0, '0, '0, 0, acc);
    collect_block("stall", acc, 5, 1, 3);

    // ENABLE low for two cycles in VERT; coefficient c -> [64,-64,-64,64]
    push4(orow(1, -1, -1, 1), orow(1, -1, -1, 1), orow(1, -1, -1, 1), orow(1, -1, -1, 1));
    send_block(irow(0, 0, 64, 0), '0, '0, '0, 0, acc);
    tick();
    ENABLE = 1'b0;
    tick();
    tick();
    check("freeze_state", OW'(STATE_DBG), OW'(1));
    check("freeze_valid", OW'(bus.OUT_VALID), OW'(0));
    ENABLE = 1'b1;
    collect_block("enable", acc, 7, -1, 0);

    // reset after two rows, then a clean DC block
    send_row(irow(1000, -500, 300, 77), acc);
    send_row(irow(-1200, 400, 900, -33), acc);
    check("pre_reset_busy", OW'(BUSY), OW'(1));
    RESET = 1'b1;
    tick();
    check_idle("mid_reset");
    RESET = 1'b0;
    push4(ones, ones, ones, ones);
    send_block(irow(64, 0, 0, 0), '0, '0, '0, 0, acc);
    collect_block("post_reset", acc, 5, -1, 0);

    check("exp_q_empty", OW'(exp_q.size()), OW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
